// File: rtl/data_seq_gen_if.sv
// Purpose : bus bundle for data_seq_gen (control inputs and data-beat outputs).
// Signals : i_start, i_stop, i_mode[1:0], i_seed[WORD_WIDTH], i_burst_len[BURST_WIDTH],
//           i_err_inject, i_ready      -> into the generator
//           o_valid, o_dout[OUTPUT_WIDTH], o_last, o_busy, o_done -> out of the generator
// Modports: master = generator side, slave = controller/consumer side.
// Widths must match the parameters of the data_seq_gen instance it connects to.
interface data_seq_gen_if #(
   parameter int unsigned OUTPUT_WIDTH = 512,
   parameter int unsigned WORD_WIDTH   = 32,
   parameter int unsigned BURST_WIDTH  = 16
);
   logic                    i_start;
   logic                    i_stop;
   logic [1:0]              i_mode;
   logic [WORD_WIDTH-1:0]   i_seed;
   logic [BURST_WIDTH-1:0]  i_burst_len;
   logic                    i_err_inject;
   logic                    i_ready;
   logic                    o_valid;
   logic [OUTPUT_WIDTH-1:0] o_dout;
   logic                    o_last;
   logic                    o_busy;
   logic                    o_done;

   modport master (
      input  i_start, i_stop, i_mode, i_seed, i_burst_len, i_err_inject, i_ready,
      output o_valid, o_dout, o_last, o_busy, o_done
   );

   modport slave (
      output i_start, i_stop, i_mode, i_seed, i_burst_len, i_err_inject, i_ready,
      input  o_valid, o_dout, o_last, o_busy, o_done
   );
endinterface

// File: rtl/data_seq_gen.sv
// Purpose : burst data-pattern generator. Each beat is NUM_WORDS words built in
//           parallel from a base word (up-count, down-count or rotate/XOR random),
//           truncated to OUTPUT_WIDTH. Base advances on every accepted beat.
// Ports   : i_clk      - clock
//           i_reset_n  - asynchronous active-low reset
//           bus        - data_seq_gen_if.master (start/stop/mode/seed/len/err/ready in,
//                        valid/dout/last/busy/done out; all outputs registered)
// Option  : define DATA_SEQ_GEN_ERR_INJ_EN to build bit-0 error injection;
//           otherwise i_err_inject is ignored.
module data_seq_gen #(
   parameter int unsigned OUTPUT_WIDTH = 512,
   parameter int unsigned WORD_WIDTH   = 32,
   parameter int unsigned BURST_WIDTH  = 16
) (
   input  logic           i_clk,
   input  logic           i_reset_n,
   data_seq_gen_if.master bus
);

   localparam int unsigned NUM_WORDS  = (OUTPUT_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
   localparam int unsigned FULL_WIDTH = NUM_WORDS * WORD_WIDTH;
   localparam logic [1:0]  MODE_UP    = 2'b00;
   localparam logic [1:0]  MODE_DOWN  = 2'b01;
   localparam logic [1:0]  MODE_RAND  = 2'b10;

   if ((WORD_WIDTH % 8 != 0) || (WORD_WIDTH < 8) || (WORD_WIDTH > OUTPUT_WIDTH)) begin : g_bad_width
      $error("data_seq_gen: WORD_WIDTH must be a multiple of 8, >= 8 and <= OUTPUT_WIDTH");
   end

   typedef enum logic {S_IDLE, S_RUN} state_t;

   // One beat from a base word; all word lanes are independent so they evaluate in parallel.
   function automatic logic [OUTPUT_WIDTH-1:0] f_beat(input logic [WORD_WIDTH-1:0] base,
                                                       input logic [1:0]            mode);
      logic [FULL_WIDTH-1:0] words;
      logic [WORD_WIDTH-1:0] idx;
      int unsigned           rot;
      words = '0;
      for (int ii = 0; ii < int'(NUM_WORDS); ii++) begin
         idx = WORD_WIDTH'(ii);
         rot = 32'(ii) % WORD_WIDTH;
         case (mode)
            MODE_DOWN: words[ii*WORD_WIDTH +: WORD_WIDTH] = base - idx;
            // rot == 0 makes the right shift a full-width shift, which yields zero
            MODE_RAND: words[ii*WORD_WIDTH +: WORD_WIDTH] =
                          ((base << rot) | (base >> (WORD_WIDTH - rot))) ^ idx;
            default:   words[ii*WORD_WIDTH +: WORD_WIDTH] = base + idx;
         endcase
      end
      return words[OUTPUT_WIDTH-1:0];
   endfunction

   state_t                  r_state,    w_nxt_state;
   logic                    r_start_d;
   logic [WORD_WIDTH-1:0]   r_base,     w_nxt_base;
   logic [1:0]              r_mode,     w_nxt_mode;
   logic [BURST_WIDTH-1:0]  r_len,      w_nxt_len;
   logic [BURST_WIDTH-1:0]  r_cnt,      w_nxt_cnt;
   logic                    r_valid,    w_nxt_valid;
   logic [OUTPUT_WIDTH-1:0] r_dout,     w_nxt_dout;
   logic                    r_last,     w_nxt_last;
   logic                    r_done,     w_nxt_done;

   logic                    w_start;
   logic                    w_accept;
   logic [1:0]              w_mode_in;
   logic [WORD_WIDTH-1:0]   w_seed_in;
   logic [WORD_WIDTH-1:0]   w_base_adv;
   logic [BURST_WIDTH-1:0]  w_cnt_inc;
   logic                    w_new_beat;
   logic [WORD_WIDTH-1:0]   w_gen_base;
   logic [1:0]              w_gen_mode;

`ifdef DATA_SEQ_GEN_ERR_INJ_EN
   logic                    r_pend,     w_nxt_pend;
   logic                    w_pend_now;
`else
   logic                    w_unused_err;
   assign w_unused_err = bus.i_err_inject;
`endif

   assign w_start   = bus.i_start & ~r_start_d;
   assign w_accept  = r_valid & bus.i_ready;
   // Reserved mode 11 behaves as up-count; a zero random seed would lock the LFSR
   assign w_mode_in = (bus.i_mode == 2'b11) ? MODE_UP : bus.i_mode;
   assign w_seed_in = ((w_mode_in == MODE_RAND) && (bus.i_seed == '0)) ? WORD_WIDTH'(1) : bus.i_seed;
   assign w_cnt_inc = r_cnt + 1'b1;

   // Base word for the beat after the current one
   always_comb begin
      w_base_adv = r_base + WORD_WIDTH'(NUM_WORDS);
      case (r_mode)
         MODE_DOWN: w_base_adv = r_base - WORD_WIDTH'(NUM_WORDS);
         MODE_RAND: w_base_adv = {r_base[WORD_WIDTH-2:0],
                                  r_base[7] ^ r_base[5] ^ r_base[4] ^ r_base[2]};
         default:   ;
      endcase
   end

   // Next-state and registered-output logic; a start always wins
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_base  = r_base;
      w_nxt_mode  = r_mode;
      w_nxt_len   = r_len;
      w_nxt_cnt   = r_cnt;
      w_nxt_valid = r_valid;
      w_nxt_dout  = r_dout;
      w_nxt_last  = r_last;
      w_nxt_done  = 1'b0;
      w_new_beat  = 1'b0;
      w_gen_base  = r_base;
      w_gen_mode  = r_mode;

      if (w_start) begin
         w_nxt_state = S_RUN;
         w_nxt_base  = w_seed_in;
         w_nxt_mode  = w_mode_in;
         w_nxt_len   = bus.i_burst_len;
         w_nxt_cnt   = '0;
         w_nxt_valid = 1'b1;
         w_nxt_last  = (bus.i_burst_len == BURST_WIDTH'(1));
         w_new_beat  = 1'b1;
         w_gen_base  = w_seed_in;
         w_gen_mode  = w_mode_in;
      end else if (r_state == S_RUN) begin
         if (w_accept) begin
            w_nxt_base = w_base_adv;
            w_nxt_cnt  = w_cnt_inc;
         end
         if ((w_accept && r_last) || bus.i_stop) begin
            w_nxt_state = S_IDLE;
            w_nxt_valid = 1'b0;
            w_nxt_last  = 1'b0;
            w_nxt_done  = 1'b1;
         end else if (w_accept) begin
            w_nxt_last = (r_len != '0) && (w_cnt_inc == r_len - 1'b1);
            w_new_beat = 1'b1;
            w_gen_base = w_base_adv;
         end
      end

      if (w_new_beat) begin
         w_nxt_dout = f_beat(w_gen_base, w_gen_mode);
      end

`ifdef DATA_SEQ_GEN_ERR_INJ_EN
      // A pending request corrupts the next beat loaded onto the bus, then clears
      w_pend_now = r_pend | bus.i_err_inject;
      w_nxt_pend = w_pend_now;
      if (w_new_beat && w_pend_now) begin
         w_nxt_dout[0] = ~w_nxt_dout[0];
         w_nxt_pend    = 1'b0;
      end
`endif
   end

   // State and output registers
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state   <= S_IDLE;
         r_start_d <= 1'b0;
         r_base    <= '0;
         r_mode    <= '0;
         r_len     <= '0;
         r_cnt     <= '0;
         r_valid   <= 1'b0;
         r_dout    <= '0;
         r_last    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_nxt_state;
         r_start_d <= bus.i_start;
         r_base    <= w_nxt_base;
         r_mode    <= w_nxt_mode;
         r_len     <= w_nxt_len;
         r_cnt     <= w_nxt_cnt;
         r_valid   <= w_nxt_valid;
         r_dout    <= w_nxt_dout;
         r_last    <= w_nxt_last;
         r_done    <= w_nxt_done;
      end
   end

`ifdef DATA_SEQ_GEN_ERR_INJ_EN
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_pend <= 1'b0;
      end else begin
         r_pend <= w_nxt_pend;
      end
   end
`endif

   assign bus.o_valid = r_valid;
   assign bus.o_busy  = r_valid;
   assign bus.o_dout  = r_dout;
   assign bus.o_last  = r_last;
   assign bus.o_done  = r_done;

endmodule

// File: tb/tb_data_seq_gen.sv
// Purpose : directed self-checking bench for data_seq_gen at 128-bit beats / 32-bit words.
// Observed status vector = {valid, busy, last, done, dout[127:0]}.
module tb_data_seq_gen;

   localparam int unsigned OW = 128;
   localparam int unsigned WW = 32;
   localparam int unsigned BW = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad   = 0;
   int   acc_cnt = 0;

   always #5 clk = ~clk;

   data_seq_gen_if #(.OUTPUT_WIDTH(OW), .WORD_WIDTH(WW), .BURST_WIDTH(BW)) bus();

   data_seq_gen #(.OUTPUT_WIDTH(OW), .WORD_WIDTH(WW), .BURST_WIDTH(BW)) dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .bus       (bus)
   );

   wire [131:0] obs = {bus.o_valid, bus.o_busy, bus.o_last, bus.o_done, bus.o_dout};

   always @(posedge clk) begin
      if (bus.o_valid === 1'b1 && bus.i_ready === 1'b1) acc_cnt++;
   end

   // Expected up-count beat for base b: words b, b+1, b+2, b+3 from low to high
   function automatic logic [127:0] up4(input logic [31:0] b);
      return {b + 32'd3, b + 32'd2, b + 32'd1, b};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic kick(input logic [1:0] m, input logic [31:0] s, input logic [15:0] l);
      bus.i_mode      = m;
      bus.i_seed      = s;
      bus.i_burst_len = l;
      bus.i_start     = 1'b1;
      tick();
      bus.i_start     = 1'b0;
   endtask

   task automatic test_reset();
      bus.i_start = 1'b0; bus.i_stop = 1'b0; bus.i_mode = 2'b00; bus.i_seed = '0;
      bus.i_burst_len = '0; bus.i_err_inject = 1'b0; bus.i_ready = 1'b1;
      #12;
      total++;
      if (obs !== 132'd0) begin bad++; $display("FAIL reset_hold: got %h want %h", obs, 132'd0); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      total++;
      if (obs !== 132'd0) begin bad++; $display("FAIL reset_idle: got %h want %h", obs, 132'd0); end
   endtask

   task automatic test_up();
      kick(2'b00, 32'h10, 16'd2);
      total++;
      if (obs !== {4'b1100, 128'h00000013_00000012_00000011_00000010}) begin
         bad++; $display("FAIL up_b0: got %h want %h", obs, {4'b1100, 128'h00000013_00000012_00000011_00000010});
      end
      tick();
      total++;
      if (obs !== {4'b1110, 128'h00000017_00000016_00000015_00000014}) begin
         bad++; $display("FAIL up_b1: got %h want %h", obs, {4'b1110, 128'h00000017_00000016_00000015_00000014});
      end
      tick();
      total++;
      if (obs[131:128] !== 4'b0001) begin bad++; $display("FAIL up_done: got %b want 0001", obs[131:128]); end
      tick();
      total++;
      if (obs[131:128] !== 4'b0000) begin bad++; $display("FAIL up_done_clr: got %b want 0000", obs[131:128]); end
   endtask

   task automatic test_down();
      kick(2'b01, 32'h10, 16'd2);
      total++;
      if (obs !== {4'b1100, 128'h0000000D_0000000E_0000000F_00000010}) begin
         bad++; $display("FAIL down_b0: got %h want %h", obs, {4'b1100, 128'h0000000D_0000000E_0000000F_00000010});
      end
      tick();
      total++;
      if (obs !== {4'b1110, 128'h00000009_0000000A_0000000B_0000000C}) begin
         bad++; $display("FAIL down_b1: got %h want %h", obs, {4'b1110, 128'h00000009_0000000A_0000000B_0000000C});
      end
      tick();
      total++;
      if (obs[131:128] !== 4'b0001) begin bad++; $display("FAIL down_done: got %b want 0001", obs[131:128]); end
      tick();
   endtask

   task automatic test_wrap();
      kick(2'b00, 32'hFFFF_FFFE, 16'd1);
      total++;
      if (obs !== {4'b1110, 128'h00000001_00000000_FFFFFFFF_FFFFFFFE}) begin
         bad++; $display("FAIL wrap_b0: got %h want %h", obs, {4'b1110, 128'h00000001_00000000_FFFFFFFF_FFFFFFFE});
      end
      tick();
      total++;
      if (obs[131:128] !== 4'b0001) begin bad++; $display("FAIL wrap_done: got %b want 0001", obs[131:128]); end
      tick();
   endtask

   task automatic test_random();
      // zero seed is replaced by 1
      kick(2'b10, 32'h0, 16'd2);
      total++;
      if (obs !== {4'b1100, 128'h0000000B_00000006_00000003_00000001}) begin
         bad++; $display("FAIL rand0_b0: got %h want %h", obs, {4'b1100, 128'h0000000B_00000006_00000003_00000001});
      end
      tick();
      total++;
      if (obs !== {4'b1110, 128'h00000013_0000000A_00000005_00000002}) begin
         bad++; $display("FAIL rand0_b1: got %h want %h", obs, {4'b1110, 128'h00000013_0000000A_00000005_00000002});
      end
      tick();
      tick();
      // seed 0x20 has tap bit 5 set, so the LFSR feeds back a 1
      kick(2'b10, 32'h20, 16'd2);
      total++;
      if (obs !== {4'b1100, 128'h00000103_00000082_00000041_00000020}) begin
         bad++; $display("FAIL rand20_b0: got %h want %h", obs, {4'b1100, 128'h00000103_00000082_00000041_00000020});
      end
      tick();
      total++;
      if (obs !== {4'b1110, 128'h0000020B_00000106_00000083_00000041}) begin
         bad++; $display("FAIL rand20_b1: got %h want %h", obs, {4'b1110, 128'h0000020B_00000106_00000083_00000041});
      end
      tick();
      tick();
   endtask

   task automatic test_reserved_mode();
      kick(2'b11, 32'h10, 16'd1);
      total++;
      if (obs !== {4'b1110, up4(32'h10)}) begin
         bad++; $display("FAIL mode11: got %h want %h", obs, {4'b1110, up4(32'h10)});
      end
      tick();
      tick();
   endtask

   task automatic test_stall();
      int snap;
      bus.i_ready = 1'b1;
      kick(2'b00, 32'h100, 16'd4);
      snap = acc_cnt;
      total++;
      if (obs !== {4'b1100, up4(32'h100)}) begin bad++; $display("FAIL stall_b0: got %h want %h", obs, {4'b1100, up4(32'h100)}); end
      tick();
      bus.i_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         total++;
         if (obs !== {4'b1100, up4(32'h104)}) begin
            bad++; $display("FAIL stall_hold%0d: got %h want %h", i, obs, {4'b1100, up4(32'h104)});
         end
      end
      bus.i_ready = 1'b1;
      tick();
      total++;
      if (obs !== {4'b1100, up4(32'h108)}) begin bad++; $display("FAIL stall_b2: got %h want %h", obs, {4'b1100, up4(32'h108)}); end
      tick();
      total++;
      if (obs !== {4'b1110, up4(32'h10C)}) begin bad++; $display("FAIL stall_b3: got %h want %h", obs, {4'b1110, up4(32'h10C)}); end
      tick();
      total++;
      if (obs[131:128] !== 4'b0001) begin bad++; $display("FAIL stall_done: got %b want 0001", obs[131:128]); end
      total++;
      if (acc_cnt - snap !== 4) begin bad++; $display("FAIL stall_count: got %0d want 4", acc_cnt - snap); end
      tick();
   endtask

   task automatic test_stop();
      int snap;
      kick(2'b00, 32'h0, 16'd0);
      snap = acc_cnt;
      for (int i = 0; i < 8; i++) begin
         total++;
         if (obs !== {4'b1100, up4(32'(4*i))}) begin
            bad++; $display("FAIL stop_b%0d: got %h want %h", i, obs, {4'b1100, up4(32'(4*i))});
         end
         if (i < 7) tick();
      end
      bus.i_stop = 1'b1;
      tick();
      bus.i_stop = 1'b0;
      total++;
      if (obs[131:128] !== 4'b0001) begin bad++; $display("FAIL stop_done: got %b want 0001", obs[131:128]); end
      total++;
      if (acc_cnt - snap !== 8) begin bad++; $display("FAIL stop_count: got %0d want 8", acc_cnt - snap); end
      tick();
      total++;
      if (obs[131:128] !== 4'b0000) begin bad++; $display("FAIL stop_idle: got %b want 0000", obs[131:128]); end
   endtask

   task automatic test_restart();
      kick(2'b00, 32'h40, 16'd0);
      tick();
      tick();
      // config changes while running must be ignored
      bus.i_seed = 32'h1000; bus.i_mode = 2'b01; bus.i_burst_len = 16'd1;
      tick();
      total++;
      if (obs !== {4'b1100, up4(32'h4C)}) begin bad++; $display("FAIL run_ignore: got %h want %h", obs, {4'b1100, up4(32'h4C)}); end
      bus.i_mode  = 2'b00;
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
      total++;
      if (obs !== {4'b1110, up4(32'h1000)}) begin bad++; $display("FAIL restart: got %h want %h", obs, {4'b1110, up4(32'h1000)}); end
      tick();
      total++;
      if (obs[131:128] !== 4'b0001) begin bad++; $display("FAIL restart_done: got %b want 0001", obs[131:128]); end
      tick();
   endtask

   task automatic test_back_to_back();
      kick(2'b00, 32'h10, 16'd2);
      tick();
      // start, stop and final-beat acceptance all in the same cycle
      bus.i_seed = 32'h200; bus.i_burst_len = 16'd2;
      bus.i_start = 1'b1; bus.i_stop = 1'b1;
      tick();
      bus.i_start = 1'b0; bus.i_stop = 1'b0;
      total++;
      if (obs !== {4'b1100, up4(32'h200)}) begin bad++; $display("FAIL b2b_b0: got %h want %h", obs, {4'b1100, up4(32'h200)}); end
      tick();
      total++;
      if (obs !== {4'b1110, up4(32'h204)}) begin bad++; $display("FAIL b2b_b1: got %h want %h", obs, {4'b1110, up4(32'h204)}); end
      tick();
      total++;
      if (obs[131:128] !== 4'b0001) begin bad++; $display("FAIL b2b_done: got %b want 0001", obs[131:128]); end
      tick();
   endtask

   task automatic test_err_inject();
      logic [127:0] exp2;
`ifdef DATA_SEQ_GEN_ERR_INJ_EN
      exp2 = up4(32'h18) ^ 128'd1;
`else
      exp2 = up4(32'h18);
`endif
      kick(2'b00, 32'h10, 16'd4);
      tick();
      total++;
      if (obs !== {4'b1100, up4(32'h14)}) begin bad++; $display("FAIL inj_b1: got %h want %h", obs, {4'b1100, up4(32'h14)}); end
      bus.i_err_inject = 1'b1;
      tick();
      bus.i_err_inject = 1'b0;
      total++;
      if (obs !== {4'b1100, exp2}) begin bad++; $display("FAIL inj_b2: got %h want %h", obs, {4'b1100, exp2}); end
      tick();
      total++;
      if (obs !== {4'b1110, up4(32'h1C)}) begin bad++; $display("FAIL inj_b3: got %h want %h", obs, {4'b1110, up4(32'h1C)}); end
      tick();
      tick();
   endtask

   task automatic test_reset_mid();
      kick(2'b00, 32'h10, 16'd0);
      tick();
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (obs !== 132'd0) begin bad++; $display("FAIL rst_async: got %h want %h", obs, 132'd0); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      tick();
      total++;
      if (obs !== 132'd0) begin bad++; $display("FAIL rst_no_resume: got %h want %h", obs, 132'd0); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_up();
      test_down();
      test_wrap();
      test_random();
      test_reserved_mode();
      test_stall();
      test_stop();
      test_restart();
      test_back_to_back();
      test_err_inject();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
